// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester arbiter and sequencer for the single-port data memory.
// The core load/store path and the DMA image loader share the memory. One
// requester is granted at a time, and each grant drives exactly one memory
// access. Read data comes back in a registered rdata with a one-cycle ack.
// The core is stalled while its access is pending.
//
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - contended grants alternate between core and DMA
//   undefined - core has fixed priority, with a starvation guard for DMA
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   core_req/we/addr/wdata -> core request (held until core_ack)
//   core_rdata, core_ack   <- registered read data, one-cycle completion pulse
//   core_stall             <- core_req & ~core_ack
//   dma_req/we/addr/wdata  -> DMA request (held until dma_ack)
//   dma_rdata, dma_ack     <- registered read data, one-cycle completion pulse
//   mem_en/we/addr/wdata   <- memory access strobe and command (held when idle)
//   mem_rdata              -> memory read data, valid MEM_LAT cycles after mem_en
//   busy                   <- high whenever the sequencer is not idle
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       gnt_dma;
    logic       pick_dma;
    logic       grant;

    // A grant is made in any idle cycle where at least one requester is asking.
    assign grant = (state == IDLE) && (core_req || dma_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dma;

    // Under contention, the requester that was not granted last wins.
    // A lone requester always wins.
    always_comb begin
        pick_dma = dma_req && (!core_req || !last_dma);
    end

    // Remember who was granted last. It resets to DMA, so the first
    // contention goes to the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dma <= 1'b1;
        end else if (grant) begin
            last_dma <= pick_dma;
        end
    end
`else
    logic [3:0] starve_cnt;

    // The core wins contention until DMA has been passed over STARVE_LIMIT
    // times in a row. After that, DMA gets the next grant.
    always_comb begin
        pick_dma = dma_req && (!core_req || (starve_cnt == 4'(STARVE_LIMIT)));
    end

    // Count core grants made while DMA was waiting, saturating at the limit.
    // Any DMA grant clears the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (grant) begin
            if (pick_dma) begin
                starve_cnt <= 4'd0;
            end else if (dma_req && (starve_cnt != 4'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    // The stall is dropped in the ack cycle so the core can advance.
    assign core_stall = core_req & ~core_ack;
    assign busy       = (state != IDLE);

    // Sequencer. The mem_* registers double as the latch for the granted
    // command, so they hold their values once the strobe has dropped.
    // Requests are sampled only in IDLE. Changes on the request inputs
    // during ISSUE/WAIT therefore cannot disturb an access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            gnt_dma    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_ack   <= 1'b0;
            dma_ack    <= 1'b0;
            core_rdata <= '0;
            dma_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_dma   <= pick_dma;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_dma ? dma_we    : core_we;
                        mem_addr  <= pick_dma ? dma_addr  : core_addr;
                        mem_wdata <= pick_dma ? dma_wdata : core_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    wait_cnt <= 4'(MEM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        if (!mem_we) begin
                            if (gnt_dma) begin
                                dma_rdata <= mem_rdata;
                            end else begin
                                core_rdata <= mem_rdata;
                            end
                        end
                        if (gnt_dma) begin
                            dma_ack <= 1'b1;
                        end else begin
                            core_ack <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    core_ack <= 1'b0;
                    dma_ack  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
